// File: rtl/switch_event_ctrl.sv
// Avalon-MM master for the switch PIO: programs irq_mask, services irqs into an event FIFO.
// irq sampled in IDLE -> ev_valid 7 cycles later; a full FIFO holds off service, ev_ready pops the head.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld && pop_rdy;
  // A pop in the same cycle frees the slot, so a push is accepted even when full.
  assign do_push = push_vld && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module switch_event_ctrl #(
  parameter int           W         = 10,
  parameter logic [W-1:0] MASK_INIT = 10'h3FF,
  parameter int           DEPTH     = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [1:0]     avm_address,
  output logic           avm_chipselect,
  output logic           avm_write_n,
  output logic [31:0]    avm_writedata,
  input  logic [31:0]    avm_readdata,
  input  logic           pio_irq,
  input  logic           cfg_valid,
  input  logic [W-1:0]   cfg_mask,
  output logic           cfg_ready,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [2*W-1:0] ev_data,
  output logic           busy
);
  typedef enum logic [3:0] {
    INIT_MASK, INIT_CLR, IDLE, WR_MASK, RD_EDGE, RD_EDGE_CAP,
    RD_DATA, RD_DATA_CAP, CLR_EDGE, PUSH
  } fsm_t;

  typedef struct packed {
    logic [W-1:0] changed;
    logic [W-1:0] snap;
  } ev_t;

  fsm_t         fsm_q, fsm_d;
  logic         out_en;
  logic [W-1:0] mask_reg, changed_q, snap_q;
  logic         ld_mask, push_vld, fifo_full;
  ev_t          push_ev, head_ev;
  logic         unused_rd;

  assign unused_rd = ^avm_readdata[31:W];

  // out_en keeps the bus quiet while in reset and delays INIT_MASK by one
  // cycle so its write is the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q     <= INIT_MASK;
      out_en    <= 1'b0;
      mask_reg  <= MASK_INIT;
      changed_q <= '0;
      snap_q    <= '0;
    end else begin
      out_en <= 1'b1;
      if (out_en)                 fsm_q     <= fsm_d;
      if (ld_mask)                mask_reg  <= cfg_mask;
      if (fsm_q == RD_EDGE_CAP)   changed_q <= avm_readdata[W-1:0] & mask_reg;
      if (fsm_q == RD_DATA_CAP)   snap_q    <= avm_readdata[W-1:0];
    end
  end

  always_comb begin
    fsm_d          = fsm_q;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 2'd0;
    avm_writedata  = 32'h0;
    cfg_ready      = 1'b0;
    ld_mask        = 1'b0;
    push_vld       = 1'b0;
    if (out_en) begin
      case (fsm_q)
        INIT_MASK: begin
          avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 2'd2;
          avm_writedata  = 32'(mask_reg);
          fsm_d          = INIT_CLR;
        end
        INIT_CLR: begin
          avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 2'd3;
          fsm_d          = IDLE;
        end
        IDLE: begin
          if (cfg_valid) begin
            cfg_ready = 1'b1;
            ld_mask   = 1'b1;
            fsm_d     = WR_MASK;
          end else if (pio_irq && !fifo_full) begin
            fsm_d = RD_EDGE;
          end
        end
        WR_MASK: begin
          avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 2'd2;
          avm_writedata  = 32'(mask_reg);
          fsm_d          = IDLE;
        end
        RD_EDGE:     begin avm_chipselect = 1'b1; avm_address = 2'd3; fsm_d = RD_EDGE_CAP; end
        RD_EDGE_CAP: begin avm_chipselect = 1'b1; avm_address = 2'd3; fsm_d = RD_DATA; end
        RD_DATA:     begin avm_chipselect = 1'b1; avm_address = 2'd0; fsm_d = RD_DATA_CAP; end
        RD_DATA_CAP: begin avm_chipselect = 1'b1; avm_address = 2'd0; fsm_d = CLR_EDGE; end
        CLR_EDGE: begin
          avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = 2'd3;
          fsm_d          = PUSH;
        end
        // Spurious irqs (all changed bits masked) are dropped here; this
        // state also covers the cycle the PIO needs to drop irq after the clear.
        PUSH: begin
          push_vld = (changed_q != '0);
          fsm_d    = IDLE;
        end
        default: fsm_d = INIT_MASK;
      endcase
    end
  end

  assign push_ev = {changed_q, snap_q};
  assign busy    = (fsm_q != IDLE);

  sync_fifo #(.WIDTH($bits(ev_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push_vld),
    .push_dat (push_ev),
    .full     (fifo_full),
    .pop_vld  (ev_valid),
    .pop_rdy  (ev_ready),
    .pop_dat  (head_ev)
  );

  assign ev_data = ev_valid ? head_ev : '0;
endmodule

// File: tb/tb_switch_event_ctrl.sv
// Bench for switch_event_ctrl with a behavioural switch PIO and an event scoreboard.
module tb_switch_event_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        pio_irq;
  logic        cfg_valid = 1'b0;
  logic [9:0]  cfg_mask = 10'h0;
  logic        cfg_ready, ev_valid, busy;
  logic        ev_ready = 1'b0;
  logic [19:0] ev_data;

  int n_checks = 0;
  int n_pass = 0;
  logic [19:0] sb[$];
  logic [19:0] exp_ev;

  // PIO model state
  logic [9:0] edge_cap = 10'h0;
  logic [9:0] in_port = 10'h0;
  logic [9:0] inj = 10'h0;
  logic [9:0] sw = 10'h0;

  localparam logic [35:0] BUS_IDLE = {1'b0, 1'b1, 2'd0, 32'h0};
  localparam logic [35:0] RD3      = {1'b1, 1'b1, 2'd3, 32'h0};
  localparam logic [35:0] RD0      = {1'b1, 1'b1, 2'd0, 32'h0};
  localparam logic [35:0] CLR3     = {1'b1, 1'b0, 2'd3, 32'h0};

  logic [35:0] bus;
  assign bus = {avm_chipselect, avm_write_n, avm_address, avm_writedata};

  switch_event_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .pio_irq(pio_irq),
    .cfg_valid(cfg_valid), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 2'd0) ? {22'h0, in_port} :
                      (avm_address == 2'd3) ? {22'h0, edge_cap} : 32'h0;
    else
      avm_readdata <= 32'h0;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_cap <= inj;
    else edge_cap <= edge_cap | inj;
    in_port <= in_port ^ inj;
  end
  assign pio_irq = |edge_cap;

  always @(negedge clk) begin
    if (reset_n && ev_valid && ev_ready) begin
      n_checks++;
      if (sb.size() == 0) $display("FAIL ev_unexpected: got %h, no event expected", ev_data);
      else begin
        exp_ev = sb.pop_front();
        if (ev_data !== exp_ev) $display("FAIL ev_data: got %h want %h", ev_data, exp_ev);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic edge_pulse(input logic [9:0] bits);
    inj = bits; sw = sw ^ bits;
    tick();
    inj = 10'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus !== BUS_IDLE) $display("FAIL rst_bus: got %h want %h", bus, BUS_IDLE); else n_pass++;
    n_checks++; if ({cfg_ready, ev_valid, busy} !== 3'b001) $display("FAIL rst_flags: got %b want 001", {cfg_ready, ev_valid, busy}); else n_pass++;
    n_checks++; if (ev_data !== 20'h0) $display("FAIL rst_ev_data: got %h want 0", ev_data); else n_pass++;
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus !== {1'b1, 1'b0, 2'd2, 32'h3FF}) $display("FAIL init_mask: got %h want %h", bus, {1'b1, 1'b0, 2'd2, 32'h3FF}); else n_pass++;
    tick();
    n_checks++; if (bus !== CLR3) $display("FAIL init_clr: got %h want %h", bus, CLR3); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL init_busy: got %b want 1", busy); else n_pass++;
    tick();
    n_checks++; if ({busy, ev_valid} !== 2'b00) $display("FAIL init_idle: got %b want 00", {busy, ev_valid}); else n_pass++;
    n_checks++; if (bus !== BUS_IDLE) $display("FAIL init_bus_idle: got %h want %h", bus, BUS_IDLE); else n_pass++;
  endtask

  task automatic test_single_edge();
    ev_ready = 1'b0;
    edge_pulse(10'h008);
    sb.push_back({10'h008, sw});
    n_checks++; if ({pio_irq, busy} !== 2'b10) $display("FAIL se_T: got %b want 10", {pio_irq, busy}); else n_pass++;
    tick();
    n_checks++; if (bus !== RD3) $display("FAIL se_rd_edge: got %h want %h", bus, RD3); else n_pass++;
    tick();
    n_checks++; if (bus !== RD3) $display("FAIL se_rd_edge_hold: got %h want %h", bus, RD3); else n_pass++;
    tick();
    n_checks++; if (bus !== RD0) $display("FAIL se_rd_data: got %h want %h", bus, RD0); else n_pass++;
    tick();
    n_checks++; if (bus !== RD0) $display("FAIL se_rd_data_hold: got %h want %h", bus, RD0); else n_pass++;
    tick();
    n_checks++; if (bus !== CLR3) $display("FAIL se_clr: got %h want %h", bus, CLR3); else n_pass++;
    tick();
    n_checks++; if ({pio_irq, ev_valid, avm_chipselect} !== 3'b000) $display("FAIL se_push: got %b want 000", {pio_irq, ev_valid, avm_chipselect}); else n_pass++;
    tick();
    n_checks++; if ({ev_valid, busy} !== 2'b10) $display("FAIL se_ev_valid: got %b want 10", {ev_valid, busy}); else n_pass++;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL se_popped: got %b want 0", ev_valid); else n_pass++;
  endtask

  task automatic test_masked();
    cfg_valid = 1'b1; cfg_mask = 10'h00F;
    #1;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready); else n_pass++;
    tick();
    cfg_valid = 1'b0;
    #1;
    n_checks++; if (bus !== {1'b1, 1'b0, 2'd2, 32'h00F}) $display("FAIL cfg_wr: got %h want %h", bus, {1'b1, 1'b0, 2'd2, 32'h00F}); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL cfg_ready_pulse: got %b want 0", cfg_ready); else n_pass++;
    tick();
    edge_pulse(10'h020);
    repeat (5) tick();
    n_checks++; if (bus !== CLR3) $display("FAIL sp_clr: got %h want %h", bus, CLR3); else n_pass++;
    tick();
    n_checks++; if ({ev_valid, pio_irq} !== 2'b00) $display("FAIL sp_push: got %b want 00", {ev_valid, pio_irq}); else n_pass++;
    tick();
    n_checks++; if ({ev_valid, busy} !== 2'b00) $display("FAIL sp_idle: got %b want 00", {ev_valid, busy}); else n_pass++;
    cfg_valid = 1'b1; cfg_mask = 10'h3FF;
    tick();
    cfg_valid = 1'b0;
    #1;
    n_checks++; if (bus !== {1'b1, 1'b0, 2'd2, 32'h3FF}) $display("FAIL cfg_restore: got %h want %h", bus, {1'b1, 1'b0, 2'd2, 32'h3FF}); else n_pass++;
    tick();
  endtask

  task automatic test_fifo_full();
    int cs_seen;
    logic [9:0] b;
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 10'd1 << i;
      edge_pulse(b);
      sb.push_back({b, sw});
      repeat (8) tick();
    end
    n_checks++; if ({ev_valid, busy} !== 2'b10) $display("FAIL full_queued: got %b want 10", {ev_valid, busy}); else n_pass++;
    edge_pulse(10'h010);
    edge_pulse(10'h040);
    cs_seen = 0;
    repeat (10) begin
      if (avm_chipselect) cs_seen++;
      tick();
    end
    n_checks++; if (cs_seen !== 0) $display("FAIL full_no_service: got %0d bus cycles want 0", cs_seen); else n_pass++;
    n_checks++; if ({pio_irq, busy} !== 2'b10) $display("FAIL full_irq_pending: got %b want 10", {pio_irq, busy}); else n_pass++;
    sb.push_back({10'h050, sw});
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    n_checks++; if ({avm_chipselect, busy} !== 2'b00) $display("FAIL full_after_pop: got %b want 00", {avm_chipselect, busy}); else n_pass++;
    tick();
    n_checks++; if (bus !== RD3) $display("FAIL full_resume: got %h want %h", bus, RD3); else n_pass++;
    ev_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0) break;
    end
    n_checks++; if (sb.size() != 0) $display("FAIL full_drain: got %0d events outstanding want 0", sb.size()); else n_pass++;
    n_checks++; if (ev_valid !== 1'b0) $display("FAIL full_empty: got %b want 0", ev_valid); else n_pass++;
    ev_ready = 1'b0;
  endtask

  task automatic test_cfg_midservice();
    ev_ready = 1'b1;
    edge_pulse(10'h100);
    sb.push_back({10'h100, sw});
    repeat (3) tick();
    cfg_valid = 1'b1; cfg_mask = 10'h3F0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (cfg_ready !== 1'b0) $display("FAIL cfg_held_%0d: got %b want 0", i, cfg_ready); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if ({cfg_ready, busy, ev_valid} !== 3'b101) $display("FAIL cfg_in_idle: got %b want 101", {cfg_ready, busy, ev_valid}); else n_pass++;
    tick();
    cfg_valid = 1'b0;
    #1;
    n_checks++; if (bus !== {1'b1, 1'b0, 2'd2, 32'h3F0}) $display("FAIL cfg_mid_wr: got %h want %h", bus, {1'b1, 1'b0, 2'd2, 32'h3F0}); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL cfg_mid_pulse: got %b want 0", cfg_ready); else n_pass++;
    tick();
    n_checks++; if (sb.size() != 0) $display("FAIL cfg_mid_event: got %0d events outstanding want 0", sb.size()); else n_pass++;
    ev_ready = 1'b0;
  endtask

  task automatic test_reset_midservice();
    ev_ready = 1'b0;
    edge_pulse(10'h010); repeat (8) tick();
    edge_pulse(10'h020); repeat (8) tick();
    n_checks++; if (ev_valid !== 1'b1) $display("FAIL rm_queued: got %b want 1", ev_valid); else n_pass++;
    edge_pulse(10'h200);
    repeat (2) tick();
    n_checks++; if (bus !== RD3) $display("FAIL rm_edge_cap: got %h want %h", bus, RD3); else n_pass++;
    reset_n = 1'b0;
    tick();
    n_checks++; if (bus !== BUS_IDLE) $display("FAIL rm_bus_idle: got %h want %h", bus, BUS_IDLE); else n_pass++;
    n_checks++; if ({ev_valid, busy, ev_data} !== {2'b01, 20'h0}) $display("FAIL rm_flush: got %h want %h", {ev_valid, busy, ev_data}, {2'b01, 20'h0}); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (bus !== {1'b1, 1'b0, 2'd2, 32'h3FF}) $display("FAIL rm_init_mask: got %h want %h", bus, {1'b1, 1'b0, 2'd2, 32'h3FF}); else n_pass++;
    tick();
    n_checks++; if (bus !== CLR3) $display("FAIL rm_init_clr: got %h want %h", bus, CLR3); else n_pass++;
    tick();
    n_checks++; if ({busy, ev_valid, pio_irq} !== 3'b000) $display("FAIL rm_idle: got %b want 000", {busy, ev_valid, pio_irq}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_masked();
    test_fifo_full();
    test_cfg_midservice();
    test_reset_midservice();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
